simd_lane_array_seq: RTL and testbench

//  Parametrised successor of the fixed 4-lane, 32-bit SIMD datapath. A single control FSM

---
 rtl/simd_pkg.sv | 23 ++
 rtl/simd_lane_alu.sv | 40 ++++
 rtl/simd_lane_array_seq.sv | 121 ++++++++++++
 tb/tb_simd_lane_array_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared opcodes, FSM encodings and default sizing for the SIMD lane array.
package simd_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_LANE_W = 32;
  localparam int DEF_SIZE_W = 6;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_MIN = 3'd6;
  localparam logic [2:0] OP_MAX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/simd_lane_alu.sv
// One combinational ALU lane: primary result plus extra word (carry/borrow/high half/compare).
module simd_lane_alu
  import simd_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic [2:0]        op,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] res,
  output logic [LANE_W-1:0] extra
);

  logic [LANE_W:0]     sum, diff;
  logic [2*LANE_W-1:0] prod;
  logic                lt;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
  assign lt   = a < b;

  always_comb begin
    res   = '0;
    extra = '0;
    case (op)
      OP_ADD: begin res = sum[LANE_W-1:0];  extra = {{(LANE_W-1){1'b0}}, sum[LANE_W]}; end
      // top bit of the widened difference is the borrow
      OP_SUB: begin res = diff[LANE_W-1:0]; extra = {{(LANE_W-1){1'b0}}, diff[LANE_W]}; end
      OP_MUL: begin res = prod[LANE_W-1:0]; extra = prod[2*LANE_W-1:LANE_W]; end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_MIN: begin res = lt ? a : b; extra = {{(LANE_W-1){1'b0}}, lt}; end
      OP_MAX: begin res = lt ? b : a; extra = {{(LANE_W-1){1'b0}}, lt}; end
      default: ;
    endcase
  end

endmodule

// File: rtl/simd_lane_array_seq.sv
// Burst-oriented SIMD datapath: control FSM plus a 2-stage operand/result pipeline
// across LANES ALU lanes, with valid/ready on both sides.
module simd_lane_array_seq
  import simd_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int SIZE_W = DEF_SIZE_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [2:0]              instruction,
  input  logic [SIZE_W-1:0]       data_size,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] opa,
  input  logic [LANES*LANE_W-1:0] opb,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_result,
  output logic [LANES*LANE_W-1:0] out_extra,
  output logic                    out_last,
  output logic                    busy
);

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

  state_t            state_q, state_d;
  logic [SIZE_W-1:0] beats_left_q, beats_left_d;
  logic [2:0]        op_q, op_d;

  logic [2:1] vld_pipe_q;
  vec_t       s1_a_q, s1_b_q, res_q, ext_q, alu_res, alu_ext;
  logic [2:0] s1_op_q;
  logic       s1_last_q, last_q;
  logic       advance, accept, acc_last, out_hs;

  // The whole pipeline freezes while the sink holds off a pending result.
  assign advance     = !vld_pipe_q[2] || out_ready;
  assign in_ready    = (state_q == ST_RUN) && advance;
  assign accept      = in_valid && in_ready;
  assign acc_last    = accept && (beats_left_q == '0);
  assign out_hs      = vld_pipe_q[2] && out_ready;
  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = vld_pipe_q[2];
  assign out_last    = last_q;
  assign out_result  = res_q;
  assign out_extra   = ext_q;

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    op_d         = op_q;
    case (state_q)
      ST_IDLE: if (instr_valid) begin
        state_d      = ST_RUN;
        beats_left_d = data_size;
        op_d         = instruction;
      end
      ST_RUN: if (accept) begin
        if (beats_left_q == '0) state_d = ST_DRAIN;
        else                    beats_left_d = beats_left_q - SIZE_W'(1);
      end
      ST_DRAIN: if (out_hs && last_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      op_q         <= '0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      op_q         <= op_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    simd_lane_alu #(.LANE_W(LANE_W)) u_alu (
      .op    (s1_op_q),
      .a     (s1_a_q[g]),
      .b     (s1_b_q[g]),
      .res   (alu_res[g]),
      .extra (alu_ext[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_last_q  <= 1'b0;
      res_q      <= '0;
      ext_q      <= '0;
      last_q     <= 1'b0;
    end else if (advance) begin
      vld_pipe_q <= {vld_pipe_q[1], accept};
      s1_last_q  <= acc_last;
      if (accept) begin
        s1_a_q  <= opa;
        s1_b_q  <= opb;
        s1_op_q <= op_q;
      end
      // last is only meaningful alongside a valid beat, so bubbles clear it
      last_q <= vld_pipe_q[1] && s1_last_q;
      if (vld_pipe_q[1]) begin
        res_q <= alu_res;
        ext_q <= alu_ext;
      end
    end
  end

endmodule

// File: tb/tb_simd_lane_array_seq.sv
// Directed bench for simd_lane_array_seq with the default 4 x 32-bit configuration.
module tb_simd_lane_array_seq;
  import simd_pkg::*;

  localparam int L  = 4;
  localparam int W  = 32;
  localparam int SW = 6;
  localparam int VW = L * W;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [2:0]    instruction = '0;
  logic [SW-1:0] data_size = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] opa = '0;
  logic [VW-1:0] opb = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_result;
  logic [VW-1:0] out_extra;
  logic          out_last;
  logic          busy;

  int total = 0;
  int bad   = 0;

  simd_lane_array_seq #(.LANES(L), .LANE_W(W), .SIZE_W(SW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .data_size   (data_size),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opa         (opa),
    .opb         (opb),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_extra   (out_extra),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [SW-1:0] sz);
    instr_valid = 1'b1;
    instruction = op;
    data_size   = sz;
    step();
    instr_valid = 1'b0;
  endtask

  // Operand patterns: t selects the test, i the beat, l the lane.
  function automatic logic [W-1:0] pat_a(input int t, input int i, input int l);
    case (t)
      3:       return W'(32'h0000_1000 * (i + 1) + l);
      4:       return W'(i * 16 + l);
      5:       return W'(i + 1);
      default: return W'((i << 24) | (l << 16) | 32'hA5A5);
    endcase
  endfunction

  function automatic logic [W-1:0] pat_b(input int t, input int i, input int l);
    case (t)
      3:       return (i == 5) ? 32'hFFFF_0000 : W'(i * 7 + l * 3);
      4:       return W'(40 - i * 10);
      5:       return 32'h1;
      default: return W'(32'h1234_0000 + i * 3);
    endcase
  endfunction

  task automatic drive_beat(input int t, input int i);
    for (int l = 0; l < L; l++) begin
      opa[l*W +: W] = pat_a(t, i, l);
      opb[l*W +: W] = pat_b(t, i, l);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (out_result !== '0) begin bad++; $display("FAIL reset_result got=%h exp=0", out_result); end
    total++; if (out_extra !== '0) begin bad++; $display("FAIL reset_extra got=%h exp=0", out_extra); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_instr_ready got=%b exp=1", instr_ready); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_add_single;
    out_ready   = 1'b1;
    instr_valid = 1'b1; instruction = OP_ADD; data_size = '0;
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL add_instr_ready got=%b exp=1", instr_ready); end
    step();
    instr_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy got=%b exp=1", busy); end
    opa = {L{32'hFFFF_FFFF}}; opb = {L{32'h1}}; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%b exp=0", out_valid); end
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    total++; if (out_result !== '0) begin bad++; $display("FAIL add_result got=%h exp=0", out_result); end
    total++; if (out_extra !== {L{32'h1}}) begin bad++; $display("FAIL add_carry got=%h exp=%h", out_extra, {L{32'h1}}); end
    total++; if (out_last !== 1'b1) begin bad++; $display("FAIL add_last got=%b exp=1", out_last); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_idle got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_mul;
    out_ready = 1'b1;
    issue(OP_MUL, 6'd1);
    opa = {L{32'd2}}; opb = {L{32'd3}};
    opa[31:0] = 32'h1234_5678; opb[31:0] = 32'h8765_4321;
    in_valid = 1'b1;
    step();
    opa = {L{32'hFFFF_FFFF}}; opb = {L{32'hFFFF_FFFF}};
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mul_valid0 got=%b exp=1", out_valid); end
    total++; if (out_result[31:0] !== 32'h70B8_8D78) begin bad++; $display("FAIL mul_lo got=%h exp=70b88d78", out_result[31:0]); end
    total++; if (out_extra[31:0] !== 32'h09A0_CD05) begin bad++; $display("FAIL mul_hi got=%h exp=09a0cd05", out_extra[31:0]); end
    total++; if (out_result[63:32] !== 32'd6 || out_extra[63:32] !== 32'd0) begin
      bad++; $display("FAIL mul_lane1 got=%h/%h exp=6/0", out_result[63:32], out_extra[63:32]); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL mul_last0 got=%b exp=0", out_last); end
    step();
    total++; if (out_result !== {L{32'h1}} || out_extra !== {L{32'hFFFF_FFFE}}) begin
      bad++; $display("FAIL mul_beat1 got=%h/%h exp=all 1/fffffffe", out_result, out_extra); end
    total++; if (out_last !== 1'b1) begin bad++; $display("FAIL mul_last1 got=%b exp=1", out_last); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mul_idle got=%b exp=0", busy); end
  endtask

  task automatic test_sub_stream;
    logic [VW-1:0] er, ee;
    logic [W-1:0]  a, b;
    out_ready = 1'b1;
    issue(OP_SUB, 6'd13);
    for (int c = 0; c <= 14; c++) begin
      if (c < 14) begin
        drive_beat(3, c); in_valid = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sub_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end else in_valid = 1'b0;
      step();
      if (c == 0) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sub_latency got=%b exp=0", out_valid); end
      end else begin
        for (int l = 0; l < L; l++) begin
          a = pat_a(3, c - 1, l); b = pat_b(3, c - 1, l);
          er[l*W +: W] = a - b;
          ee[l*W +: W] = (a < b) ? 32'h1 : 32'h0;
        end
        total++; if (out_valid !== 1'b1 || out_result !== er || out_extra !== ee || out_last !== (c == 14)) begin
          bad++; $display("FAIL sub_beat%0d got=%b %h %h %b exp=1 %h %h %b",
                          c - 1, out_valid, out_result, out_extra, out_last, er, ee, (c == 14)); end
      end
    end
    step();
    total++; if (busy !== 1'b0 || instr_ready !== 1'b1) begin bad++; $display("FAIL sub_idle got=%b/%b exp=0/1", busy, instr_ready); end
  endtask

  task automatic test_backpressure;
    logic [VW-1:0] er, ee, prev_r, prev_e;
    logic [W-1:0]  a, b;
    logic          prev_l, prev_stall, in_hs;
    int            ii, oi;
    ii = 0; oi = 0; prev_stall = 1'b0; prev_r = '0; prev_e = '0; prev_l = 1'b0;
    issue(OP_MAX, 6'd3);
    for (int c = 0; c < 40 && oi < 4; c++) begin
      out_ready = !(c >= 2 && c < 7);
      if (ii < 4) begin drive_beat(4, ii); in_valid = 1'b1; end else in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        total++; if (out_valid !== 1'b1 || out_result !== prev_r || out_extra !== prev_e || out_last !== prev_l) begin
          bad++; $display("FAIL bp_hold c=%0d got=%h %h exp=%h %h", c, out_result, out_extra, prev_r, prev_e); end
      end
      if (out_valid && !out_ready) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, in_ready); end
      end
      if (out_valid && out_ready) begin
        for (int l = 0; l < L; l++) begin
          a = pat_a(4, oi, l); b = pat_b(4, oi, l);
          er[l*W +: W] = (a > b) ? a : b;
          ee[l*W +: W] = (a < b) ? 32'h1 : 32'h0;
        end
        total++; if (out_result !== er || out_extra !== ee || out_last !== (oi == 3)) begin
          bad++; $display("FAIL bp_beat%0d got=%h %h %b exp=%h %h %b", oi, out_result, out_extra, out_last, er, ee, (oi == 3)); end
        oi++;
      end
      prev_stall = out_valid && !out_ready;
      prev_r = out_result; prev_e = out_extra; prev_l = out_last;
      in_hs = in_valid && in_ready;
      step();
      if (in_hs) ii++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (oi !== 4 || ii !== 4) begin bad++; $display("FAIL bp_count got=%0d/%0d exp=4/4", ii, oi); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b exp=0", busy); end
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b1;
    issue(OP_ADD, 6'd7);
    for (int i = 0; i < 3; i++) begin
      drive_beat(5, i); in_valid = 1'b1;
      step();
    end
    drive_beat(5, 3);
    total++; if (out_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rst_inflight got=%b/%b exp=1/1", out_valid, busy); end
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_ctrl got=%b %b %b exp=0 0 0", out_valid, out_last, busy); end
    total++; if (out_result !== '0 || out_extra !== '0) begin bad++; $display("FAIL rst_data got=%h %h exp=0 0", out_result, out_extra); end
    total++; if (in_ready !== 1'b0 || instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b/%b exp=0/1", in_ready, instr_ready); end
    in_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_no_resume got=%b exp=0", out_valid); end
    issue(OP_OR, 6'd0);
    opa = {L{32'hF0F0_F0F0}}; opb = {L{32'h0F0F_0F0F}}; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || out_result !== {L{32'hFFFF_FFFF}} || out_extra !== '0 || out_last !== 1'b1) begin
      bad++; $display("FAIL rst_next got=%b %h %h %b exp=1 all-ones 0 1", out_valid, out_result, out_extra, out_last); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_next_idle got=%b exp=0", busy); end
  endtask

  task automatic test_protocol;
    logic [VW-1:0] er;
    logic          in_hs;
    int            ii, oi, nlast;
    ii = 0; oi = 0; nlast = 0;
    out_ready = 1'b1;
    drive_beat(6, 99); in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL proto_idle_in_ready got=%b exp=0", in_ready); end
      step();
    end
    step();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL proto_idle_ignore got=%b/%b exp=0/0", out_valid, busy); end
    in_valid = 1'b0;
    issue(OP_XOR, 6'h3F);
    instr_valid = 1'b1; instruction = OP_ADD; data_size = '0;
    for (int c = 0; c < 300 && oi < 64; c++) begin
      out_ready = (c % 7) != 3;
      if (ii < 64) begin drive_beat(6, ii); in_valid = 1'b1; end else in_valid = 1'b0;
      #1;
      if (c % 16 == 0) begin
        total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL proto_instr_ready c=%0d got=%b exp=0", c, instr_ready); end
      end
      if (out_valid && out_ready) begin
        for (int l = 0; l < L; l++) er[l*W +: W] = pat_a(6, oi, l) ^ pat_b(6, oi, l);
        total++; if (out_result !== er || out_extra !== '0 || out_last !== (oi == 63)) begin
          bad++; $display("FAIL proto_beat%0d got=%h %h %b exp=%h 0 %b", oi, out_result, out_extra, out_last, er, (oi == 63)); end
        if (out_last) nlast++;
        oi++;
      end
      in_hs = in_valid && in_ready;
      step();
      if (in_hs) ii++;
    end
    instr_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    total++; if (ii !== 64 || oi !== 64 || nlast !== 1) begin
      bad++; $display("FAIL proto_count got=%0d in %0d out %0d last exp=64 64 1", ii, oi, nlast); end
    step();
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL proto_end got=%b/%b exp=0/0", busy, out_valid); end
  endtask

  initial begin
    test_reset();
    test_add_single();
    test_mul();
    test_sub_stream();
    test_backpressure();
    test_mid_reset();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
